// File: rtl/rotary_pkg.sv
// rtl/rotary_pkg.sv - shared types and default constants for the rotary step arbiter
package rotary_pkg;

    // Arbiter FSM: pick a slot, compute the new position, write it back
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_e;

    // Contents of one player's one-deep pending slot
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        INC   = 2'd1,
        DEC   = 2'd2
    } slot_e;

    localparam int DEF_STEP    = 15;
    localparam int DEF_MIN_POS = 0;
    localparam int DEF_MAX_POS = 620;

    localparam int POS_W   = 16;
    localparam int RPOS_W  = 12;
    localparam int SUM_W   = 18;

endpackage

// File: rtl/rotary_req_slot.sv
// rtl/rotary_req_slot.sv - one-deep pending step slot with capture/drop logic for one player
import rotary_pkg::*;

module rotary_req_slot (
    input  logic  clk,
    input  logic  reset,
    input  logic  inc,
    input  logic  dec,
    input  logic  clr,
    output slot_e slot,
    output logic  full,
    output logic  drop
);

    slot_e slot_q, slot_d;
    logic  drop_q, drop_d;
    logic  req;
    logic  occupied;

    // Capture a lone inc/dec; a slot being cleared this cycle counts as free
    always_comb begin
        slot_d   = slot_q;
        drop_d   = 1'b0;
        req      = inc ^ dec;
        occupied = (slot_q != EMPTY) && !clr;
        if (clr) begin
            slot_d = EMPTY;
        end
        if (req) begin
            if (occupied) begin
                drop_d = 1'b1;
            end else begin
                slot_d = inc ? INC : DEC;
            end
        end
    end

    // Slot and drop-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= EMPTY;
            drop_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            drop_q <= drop_d;
        end
    end

    assign slot = slot_q;
    assign full = (slot_q != EMPTY);
    assign drop = drop_q;

endmodule

// File: rtl/rotary_step_arbiter.sv
// rtl/rotary_step_arbiter.sv - round-robin shared +/-STEP datapath for two paddle positions (option: POS_CLAMP_EN)
import rotary_pkg::*;

module rotary_step_arbiter #(
    parameter int STEP    = DEF_STEP,
    parameter int MIN_POS = DEF_MIN_POS,
    parameter int MAX_POS = DEF_MAX_POS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RPOS_W-1:0] reset_pos0,
    input  logic [RPOS_W-1:0] reset_pos1,
    input  logic              inc0,
    input  logic              dec0,
    input  logic              inc1,
    input  logic              dec1,
    output logic [POS_W-1:0]  pos0,
    output logic [POS_W-1:0]  pos1,
    output logic              upd0,
    output logic              upd1,
    output logic              drop0,
    output logic              drop1,
    output logic              busy
);

    state_e             state_q;
    logic               last_grant_q;
    logic               grant_q;
    logic               dir_dec_q;
    logic [POS_W-1:0]   result_q;
    logic [POS_W-1:0]   pos0_q, pos1_q;
    logic               upd0_q, upd1_q;
    logic               busy_q;

    slot_e              slot0, slot1;
    logic               full0, full1;
    logic               clr0, clr1;
    logic               grant_pick;
    slot_e              pick_slot;
    logic [POS_W-1:0]   pos_sel;
    logic [POS_W-1:0]   result_d;

    // The granted slot is released in the same cycle its result lands
    assign clr0 = (state_q == WRITE) && !grant_q;
    assign clr1 = (state_q == WRITE) &&  grant_q;

    rotary_req_slot u_slot0 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc0),
        .dec   (dec0),
        .clr   (clr0),
        .slot  (slot0),
        .full  (full0),
        .drop  (drop0)
    );

    rotary_req_slot u_slot1 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc1),
        .dec   (dec1),
        .clr   (clr1),
        .slot  (slot1),
        .full  (full1),
        .drop  (drop1)
    );

    // Round-robin choice: lone full slot wins, a tie goes to whoever was not served last
    always_comb begin
        grant_pick = 1'b0;
        if (full0 && full1) begin
            grant_pick = ~last_grant_q;
        end else if (full1) begin
            grant_pick = 1'b1;
        end
        pick_slot = grant_pick ? slot1 : slot0;
    end

`ifdef POS_CLAMP_EN
    localparam logic signed [SUM_W-1:0] STEP_S = SUM_W'(STEP);
    localparam logic signed [SUM_W-1:0] MIN_S  = SUM_W'(MIN_POS);
    localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(MAX_POS);
    localparam logic [POS_W-1:0]        MIN_P  = POS_W'(MIN_POS);
    localparam logic [POS_W-1:0]        MAX_P  = POS_W'(MAX_POS);

    logic signed [SUM_W-1:0] operand;
    logic signed [SUM_W-1:0] sum;

    // Shared adder in 18-bit signed arithmetic, then clamp into [MIN_POS, MAX_POS]
    always_comb begin
        pos_sel  = grant_q ? pos1_q : pos0_q;
        operand  = {2'b00, pos_sel};
        sum      = dir_dec_q ? (operand - STEP_S) : (operand + STEP_S);
        result_d = sum[POS_W-1:0];
        if (!dir_dec_q && (sum > MAX_S)) begin
            result_d = MAX_P;
        end else if (dir_dec_q && (sum < MIN_S)) begin
            result_d = MIN_P;
        end
    end
`else
    localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);

    // Shared adder; only the low 16 bits of the signed sum survive, so positions wrap
    always_comb begin
        pos_sel  = grant_q ? pos1_q : pos0_q;
        result_d = dir_dec_q ? (pos_sel - STEP_P) : (pos_sel + STEP_P);
    end
`endif

    // Arbiter FSM with position registers and registered pulse/busy outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            dir_dec_q    <= 1'b0;
            result_q     <= '0;
            pos0_q       <= {4'b0000, reset_pos0};
            pos1_q       <= {4'b0000, reset_pos1};
            upd0_q       <= 1'b0;
            upd1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            upd0_q <= 1'b0;
            upd1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (full0 || full1) begin
                        grant_q      <= grant_pick;
                        last_grant_q <= grant_pick;
                        dir_dec_q    <= (pick_slot == DEC);
                        state_q      <= CALC;
                        busy_q       <= 1'b1;
                    end
                end
                CALC: begin
                    result_q <= result_d;
                    state_q  <= WRITE;
                end
                WRITE: begin
                    if (grant_q) begin
                        pos1_q <= result_q;
                        upd1_q <= 1'b1;
                    end else begin
                        pos0_q <= result_q;
                        upd0_q <= 1'b1;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pos0 = pos0_q;
    assign pos1 = pos1_q;
    assign upd0 = upd0_q;
    assign upd1 = upd1_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_rotary_step_arbiter.sv
// tb/tb_rotary_step_arbiter.sv - directed self-checking bench for rotary_step_arbiter
module tb_rotary_step_arbiter;

    logic        clk;
    logic        reset;
    logic [11:0] reset_pos0;
    logic [11:0] reset_pos1;
    logic        inc0, dec0, inc1, dec1;
    logic [15:0] pos0, pos1;
    logic        upd0, upd1, drop0, drop1, busy;

    int n_checks;
    int n_fail;

`ifdef POS_CLAMP_EN
    localparam int EXP_HI_POS0 = 620;
    localparam int EXP_LO_POS1 = 0;
`else
    localparam int EXP_HI_POS0 = 625;
    localparam int EXP_LO_POS1 = 65526;
`endif

    rotary_step_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .reset_pos0 (reset_pos0),
        .reset_pos1 (reset_pos1),
        .inc0       (inc0),
        .dec0       (dec0),
        .inc1       (inc1),
        .dec1       (dec1),
        .pos0       (pos0),
        .pos1       (pos1),
        .upd0       (upd0),
        .upd1       (upd1),
        .drop0      (drop0),
        .drop1      (drop1),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [11:0] p0, input logic [11:0] p1);
        reset      = 1'b1;
        reset_pos0 = p0;
        reset_pos1 = p1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse(input logic i0, input logic d0, input logic i1, input logic d1);
        inc0 = i0;
        dec0 = d0;
        inc1 = i1;
        dec1 = d1;
        tick();
        inc0 = 1'b0;
        dec0 = 1'b0;
        inc1 = 1'b0;
        dec1 = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        clk        = 1'b0;
        reset      = 1'b1;
        reset_pos0 = '0;
        reset_pos1 = '0;
        inc0 = 1'b0; dec0 = 1'b0; inc1 = 1'b0; dec1 = 1'b0;
        @(negedge clk);

        do_reset(12'd300, 12'd100);
        expect_eq("rst_pos0", pos0, 300);
        expect_eq("rst_pos1", pos1, 100);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_upd0", upd0, 0);
        expect_eq("rst_upd1", upd1, 0);
        expect_eq("rst_drop0", drop0, 0);
        expect_eq("rst_drop1", drop1, 0);

        // inc0 and dec1 together: player 0 wins the first tie
        pulse(1, 0, 0, 1);
        expect_eq("tie_busy_e0", busy, 0);
        tick();
        expect_eq("tie_busy_e1", busy, 1);
        tick();
        expect_eq("tie_pos0_e2", pos0, 300);
        tick();
        expect_eq("tie_pos0_e3", pos0, 315);
        expect_eq("tie_upd0_e3", upd0, 1);
        expect_eq("tie_upd1_e3", upd1, 0);
        expect_eq("tie_pos1_e3", pos1, 100);
        tick();
        expect_eq("tie_upd0_e4", upd0, 0);
        tick();
        tick();
        expect_eq("tie_pos1_e6", pos1, 85);
        expect_eq("tie_upd1_e6", upd1, 1);
        expect_eq("tie_pos0_e6", pos0, 315);
        tick();
        expect_eq("tie_busy_e7", busy, 0);
        expect_eq("tie_upd1_e7", upd1, 0);

        // single inc0: 3-cycle latency
        pulse(1, 0, 0, 0);
        tick();
        tick();
        expect_eq("single_upd0_e2", upd0, 0);
        tick();
        expect_eq("single_pos0", pos0, 330);
        expect_eq("single_upd0", upd0, 1);
        tick();

        // slot-full drops and store-on-clear
        pulse(1, 0, 0, 0);
        tick();
        pulse(1, 0, 0, 0);
        expect_eq("drop_full_e2", drop0, 1);
        pulse(1, 0, 0, 0);
        expect_eq("drop_on_clear_e3", drop0, 0);
        expect_eq("drop_upd0_e3", upd0, 1);
        expect_eq("drop_pos0_e3", pos0, 345);
        pulse(1, 0, 0, 0);
        expect_eq("drop_full_e4", drop0, 1);
        expect_eq("drop_busy_e4", busy, 1);
        tick();
        tick();
        expect_eq("drop_pos0_e6", pos0, 360);
        expect_eq("drop_upd0_e6", upd0, 1);
        expect_eq("drop_pulse_e6", drop0, 0);
        tick(); tick(); tick(); tick();
        expect_eq("drop_pos0_settled", pos0, 360);
        expect_eq("drop_busy_settled", busy, 0);

        // tie again with player 0 served last: player 1 goes first
        pulse(1, 0, 1, 0);
        tick(); tick(); tick();
        expect_eq("rr_pos1_first", pos1, 100);
        expect_eq("rr_upd1_first", upd1, 1);
        expect_eq("rr_pos0_wait", pos0, 360);
        tick(); tick(); tick();
        expect_eq("rr_pos0_second", pos0, 375);
        expect_eq("rr_upd0_second", upd0, 1);
        tick();

        // inc1 and dec1 together are ignored
        pulse(0, 0, 1, 1);
        expect_eq("pair_drop1_e0", drop1, 0);
        tick();
        expect_eq("pair_busy_e1", busy, 0);
        expect_eq("pair_drop1_e1", drop1, 0);
        tick(); tick();
        expect_eq("pair_pos1", pos1, 100);
        expect_eq("pair_upd1", upd1, 0);

        // bound behaviour: clamp or wrap depending on build
        do_reset(12'd610, 12'd5);
        pulse(1, 0, 0, 1);
        tick(); tick(); tick();
        expect_eq("bound_pos0_hi", pos0, EXP_HI_POS0);
        tick(); tick(); tick();
        expect_eq("bound_pos1_lo", pos1, EXP_LO_POS1);
        expect_eq("bound_upd1", upd1, 1);
        tick();

        // reset during CALC aborts the update
        pulse(1, 0, 0, 0);
        tick();
        expect_eq("abort_busy_calc", busy, 1);
        reset      = 1'b1;
        reset_pos0 = 12'd50;
        reset_pos1 = 12'd60;
        tick();
        reset = 1'b0;
        expect_eq("abort_pos0", pos0, 50);
        expect_eq("abort_pos1", pos1, 60);
        expect_eq("abort_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_eq("abort_no_upd0", upd0, 0);
        end
        expect_eq("abort_pos0_final", pos0, 50);
        expect_eq("abort_busy_final", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
